// File: rtl/spiral_unroll_if.sv
// spiral_unroll_if: handshake bundle between a spiral-order source, the unroll block and a
// raster-order sink.
//   row, col        frame dimensions, sampled by the slave on the first word of a frame
//   data_in*        spiral-ordered input stream (valid/rdy)
//   data_out*       raster-ordered output stream (valid/rdy)
// master: the environment (drives input stream and output ready)
// slave : the spiral_unroll block
interface spiral_unroll_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned R_WIDTH    = 3,
    parameter int unsigned C_WIDTH    = 3
);
    logic [R_WIDTH-1:0]    row;
    logic [C_WIDTH-1:0]    col;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_in_valid;
    logic                  data_in_rdy;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_valid;
    logic                  data_out_rdy;

    modport master (
        output row, col, data_in, data_in_valid, data_out_rdy,
        input  data_in_rdy, data_out, data_out_valid
    );

    modport slave (
        input  row, col, data_in, data_in_valid, data_out_rdy,
        output data_in_rdy, data_out, data_out_valid
    );
endinterface

// File: rtl/spiral_unroll.sv
// spiral_unroll: collects one row x col frame arriving in clockwise spiral order (starting
// top-left) into a buffer, then replays it in raster order.
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset
//   bus   spiral_unroll_if slave: row/col, spiral input stream, raster output stream
module spiral_unroll #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned R_WIDTH    = 3,
    parameter int unsigned C_WIDTH    = 3
) (
    input  logic           clk,
    input  logic           rstn,
    spiral_unroll_if.slave bus
);
    localparam int unsigned AW    = R_WIDTH + C_WIDTH;
    localparam int unsigned Depth = 1 << AW;

    localparam logic [R_WIDTH-1:0] ROne = R_WIDTH'(1);
    localparam logic [C_WIDTH-1:0] COne = C_WIDTH'(1);
    localparam logic [AW-1:0]      AOne = AW'(1);

    typedef enum logic [1:0] {StIdle, StFill, StDrain} state_e;
    typedef enum logic [1:0] {DirRight, DirDown, DirLeft, DirUp} dir_e;

    state_e             state_q;
    logic [R_WIDTH-1:0] rows_q;
    logic [C_WIDTH-1:0] cols_q;
    logic [AW-1:0]      total_q;
    logic [AW-1:0]      count_q;

    // Spiral walker: current write position, shrinking bounds and heading
    logic [R_WIDTH-1:0] r_q, top_q, bot_q;
    logic [C_WIDTH-1:0] c_q, left_q, right_q;
    dir_e               dir_q;

    // Raster read position
    logic [R_WIDTH-1:0] rr_q;
    logic [C_WIDTH-1:0] cc_q;

    logic [DATA_WIDTH-1:0] mem_q [Depth];

    logic in_rdy, in_hs, out_valid, out_hs;
    logic [AW-1:0] prod, wr_addr;

    // Walker step inputs (w_*) and results (n_*)
    logic [R_WIDTH-1:0] w_r, w_top, w_bot, n_r, n_top, n_bot;
    logic [C_WIDTH-1:0] w_c, w_left, w_right, n_c, n_left, n_right;
    dir_e               w_dir, n_dir;

    // Gated by rstn so the block never advertises space while held in reset
    assign in_rdy    = rstn && (((state_q == StIdle) && (bus.row != '0) && (bus.col != '0)) ||
                                (state_q == StFill));
    assign in_hs     = bus.data_in_valid && in_rdy;
    assign out_valid = (state_q == StDrain);
    assign out_hs    = out_valid && bus.data_out_rdy;

    assign bus.data_in_rdy    = in_rdy;
    assign bus.data_out_valid = out_valid;
    assign bus.data_out       = out_valid ? mem_q[{rr_q, cc_q}] : '0;

    // Product fits in AW bits since (2^R-1)*(2^C-1) < 2^(R+C)
    assign prod    = {{C_WIDTH{1'b0}}, bus.row} * {{R_WIDTH{1'b0}}, bus.col};
    assign wr_addr = (state_q == StIdle) ? '0 : {r_q, c_q};

    always_comb begin
        // The first word of a frame steps from (0,0) with bounds taken from the live row/col
        if (state_q == StIdle) begin
            w_r     = '0;
            w_c     = '0;
            w_top   = '0;
            w_bot   = bus.row - ROne;
            w_left  = '0;
            w_right = bus.col - COne;
            w_dir   = DirRight;
        end else begin
            w_r     = r_q;
            w_c     = c_q;
            w_top   = top_q;
            w_bot   = bot_q;
            w_left  = left_q;
            w_right = right_q;
            w_dir   = dir_q;
        end

        n_r     = w_r;
        n_c     = w_c;
        n_top   = w_top;
        n_bot   = w_bot;
        n_left  = w_left;
        n_right = w_right;
        n_dir   = w_dir;

        // Wrap-around past the final word is harmless: termination is by count only
        unique case (w_dir)
            DirRight: begin
                if (w_c == w_right) begin
                    n_top = w_top + ROne;
                    n_dir = DirDown;
                    n_r   = w_r + ROne;
                end else begin
                    n_c = w_c + COne;
                end
            end
            DirDown: begin
                if (w_r == w_bot) begin
                    n_right = w_right - COne;
                    n_dir   = DirLeft;
                    n_c     = w_c - COne;
                end else begin
                    n_r = w_r + ROne;
                end
            end
            DirLeft: begin
                if (w_c == w_left) begin
                    n_bot = w_bot - ROne;
                    n_dir = DirUp;
                    n_r   = w_r - ROne;
                end else begin
                    n_c = w_c - COne;
                end
            end
            DirUp: begin
                if (w_r == w_top) begin
                    n_left = w_left + COne;
                    n_dir  = DirRight;
                    n_c    = w_c + COne;
                end else begin
                    n_r = w_r - ROne;
                end
            end
            default: ;
        endcase
    end

    // Frame buffer, deliberately without reset
    always_ff @(posedge clk) begin
        if (in_hs) begin
            mem_q[wr_addr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            rows_q  <= '0;
            cols_q  <= '0;
            total_q <= '0;
            count_q <= '0;
            r_q     <= '0;
            c_q     <= '0;
            top_q   <= '0;
            bot_q   <= '0;
            left_q  <= '0;
            right_q <= '0;
            dir_q   <= DirRight;
            rr_q    <= '0;
            cc_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_hs) begin
                        rows_q  <= bus.row;
                        cols_q  <= bus.col;
                        total_q <= prod;
                        count_q <= AOne;
                        r_q     <= n_r;
                        c_q     <= n_c;
                        top_q   <= n_top;
                        bot_q   <= n_bot;
                        left_q  <= n_left;
                        right_q <= n_right;
                        dir_q   <= n_dir;
                        rr_q    <= '0;
                        cc_q    <= '0;
                        state_q <= (prod == AOne) ? StDrain : StFill;
                    end
                end
                StFill: begin
                    if (in_hs) begin
                        r_q     <= n_r;
                        c_q     <= n_c;
                        top_q   <= n_top;
                        bot_q   <= n_bot;
                        left_q  <= n_left;
                        right_q <= n_right;
                        dir_q   <= n_dir;
                        count_q <= count_q + AOne;
                        if (count_q == total_q - AOne) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (out_hs) begin
                        if (cc_q == cols_q - COne) begin
                            cc_q <= '0;
                            if (rr_q == rows_q - ROne) begin
                                rr_q    <= '0;
                                state_q <= StIdle;
                            end else begin
                                rr_q <= rr_q + ROne;
                            end
                        end else begin
                            cc_q <= cc_q + COne;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
